// File: rtl/mpc_mem_arbiter.sv
// Round-robin arbiter letting NUM_MASTERS Avalon-MM masters share one single-port
// on-chip memory, with read data steered back to the issuing master.
module mpc_mem_arbiter #(
  parameter int NUM_MASTERS  = 4,
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 32,
  parameter int BE_W         = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
  input  logic [NUM_MASTERS*BE_W-1:0]   m_byteenable,
  input  logic [NUM_MASTERS-1:0]        m_read,
  input  logic [NUM_MASTERS-1:0]        m_write,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_writedata,
  output logic [NUM_MASTERS-1:0]        m_waitrequest,
  output logic [DATA_W-1:0]             m_readdata,
  output logic [NUM_MASTERS-1:0]        m_readdatavalid,
  output logic [ADDR_W-1:0]             mem_address,
  output logic [BE_W-1:0]               mem_byteenable,
  output logic                          mem_chipselect,
  output logic                          mem_write,
  output logic [DATA_W-1:0]             mem_writedata,
  output logic                          mem_clken,
  input  logic [DATA_W-1:0]             mem_readdata
);

  localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [NUM_MASTERS-1:0]  req;
  logic                    hit_any;
  logic                    gnt_valid;
  logic [PTR_W-1:0]        gnt_idx;
  logic                    rd_accept;
  logic [READ_LATENCY-1:0] rd_valid_q, rd_valid_d;
  logic [PTR_W-1:0]        rd_tag_q [READ_LATENCY];
  logic [PTR_W-1:0]        rd_tag_d [READ_LATENCY];

  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
    return PTR_W'(s);
  endfunction

  assign req = m_read | m_write;

  // Search downward from the farthest offset so the nearest requester to ptr wins last.
  always_comb begin
    hit_any = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      gnt_idx = req[wrap_idx(ptr_q, k)] ? wrap_idx(ptr_q, k) : gnt_idx;
      hit_any = hit_any | req[wrap_idx(ptr_q, k)];
    end
    gnt_valid = hit_any & ~reset;
  end

  // Steer the granted master onto the memory port and advance the pointer.
  always_comb begin
    m_waitrequest  = '1;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    rd_accept      = 1'b0;
    ptr_d          = ptr_q;
    if (gnt_valid) begin
      m_waitrequest[gnt_idx] = 1'b0;
      mem_chipselect = 1'b1;
      mem_write      = m_write[gnt_idx];
      mem_address    = m_address[int'(gnt_idx)*ADDR_W +: ADDR_W];
      mem_byteenable = m_byteenable[int'(gnt_idx)*BE_W +: BE_W];
      mem_writedata  = m_writedata[int'(gnt_idx)*DATA_W +: DATA_W];
      // Read+write together is a write and must not produce readdatavalid.
      rd_accept      = m_read[gnt_idx] & ~m_write[gnt_idx];
      ptr_d          = (gnt_idx == PTR_W'(NUM_MASTERS - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Read tag pipeline matching the memory read latency.
  always_comb begin
    rd_valid_d = '0;
    for (int i = 0; i < READ_LATENCY; i++) rd_tag_d[i] = '0;
    rd_valid_d[0] = rd_accept;
    rd_tag_d[0]   = gnt_idx;
    for (int i = 1; i < READ_LATENCY; i++) begin
      rd_valid_d[i] = rd_valid_q[i-1];
      rd_tag_d[i]   = rd_tag_q[i-1];
    end
  end

  // State registers; reset drops any reads still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q      <= '0;
      rd_valid_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rd_valid_q <= rd_valid_d;
    end
    for (int i = 0; i < READ_LATENCY; i++) rd_tag_q[i] <= rd_tag_d[i];
  end

  assign m_readdata      = mem_readdata;
  assign m_readdatavalid = (rd_valid_q[READ_LATENCY-1] & ~reset)
                         ? (NUM_MASTERS'(1) << rd_tag_q[READ_LATENCY-1]) : '0;
  assign mem_clken       = ~reset;

endmodule

// File: tb/tb_mpc_mem_arbiter.sv
// Directed bench for mpc_mem_arbiter with a 1-cycle-latency byte-enabled memory model.
module tb_mpc_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int BW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N*AW-1:0] m_address;
  logic [N*BW-1:0] m_byteenable;
  logic [N-1:0]    m_read, m_write;
  logic [N*DW-1:0] m_writedata;
  logic [N-1:0]    m_waitrequest, m_readdatavalid;
  logic [DW-1:0]   m_readdata;
  logic [AW-1:0]   mem_address;
  logic [BW-1:0]   mem_byteenable;
  logic            mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0]   mem_writedata, mem_readdata;

  logic [DW-1:0]   mem [0:8191];
  logic            pl_en = 1'b0;
  logic [AW-1:0]   pl_addr = '0;
  logic [DW-1:0]   pl_data = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt [N];

  always #5 clk = ~clk;

  mpc_mem_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .READ_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .m_address(m_address), .m_byteenable(m_byteenable),
    .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  // Memory model: registered read, byte-enabled write, plus a bench preload port.
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) mem[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end else begin
        mem_readdata <= mem[mem_address];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    next_cycle();
    pl_en   = 1'b0;
  endtask

  task automatic set_master(input int i, input logic [AW-1:0] a, input logic [BW-1:0] be,
                            input logic [DW-1:0] d);
    m_address[i*AW +: AW]    = a;
    m_byteenable[i*BW +: BW] = be;
    m_writedata[i*DW +: DW]  = d;
  endtask

  initial begin
    reset        = 1'b1;
    m_address    = '0;
    m_byteenable = '0;
    m_writedata  = '0;
    m_read       = 4'b1111;
    m_write      = 4'b0000;
    mem_readdata = '0;

    // Reset state with every master requesting
    @(negedge clk);
    check_eq("rst_waitreq", 32'(m_waitrequest), 32'h0000000F);
    check_eq("rst_cs", 32'(mem_chipselect), 32'h0);
    check_eq("rst_rdv", 32'(m_readdatavalid), 32'h0);
    check_eq("rst_clken", 32'(mem_clken), 32'h0);
    next_cycle();
    preload(13'h0005, 32'hDEADBEEF);
    preload(13'h1FFF, 32'hAAAAAAAA);
    for (int i = 0; i < N; i++) preload(13'(13'h0100 + i), 32'hC0DE0000 + 32'(i));

    reset  = 1'b0;
    m_read = 4'b0000;
    @(negedge clk);
    check_eq("idle_clken", 32'(mem_clken), 32'h1);
    check_eq("idle_cs", 32'(mem_chipselect), 32'h0);
    check_eq("idle_waitreq", 32'(m_waitrequest), 32'h0000000F);

    // Single read from master 2
    next_cycle();
    set_master(2, 13'h0005, 4'b1111, 32'h0);
    m_read = 4'b0100;
    @(negedge clk);
    check_eq("sr_waitreq", 32'(m_waitrequest), 32'h0000000B);
    check_eq("sr_cs", 32'(mem_chipselect), 32'h1);
    check_eq("sr_addr", 32'(mem_address), 32'h00000005);
    check_eq("sr_memwr", 32'(mem_write), 32'h0);
    next_cycle();
    m_read = 4'b0000;
    @(negedge clk);
    check_eq("sr_rdv", 32'(m_readdatavalid), 32'h00000004);
    check_eq("sr_data", m_readdata, 32'hDEADBEEF);

    // Reset pulse to bring ptr back to 0, then full contention
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      set_master(i, 13'(13'h0100 + i), 4'b1111, 32'h0);
      cnt[i] = 0;
    end
    m_read = 4'b1111;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c < 8) check_eq("ct_waitreq", 32'(m_waitrequest), 32'(~(4'b0001 << (c % 4)) & 4'hF));
      if (c == 0) begin
        check_eq("ct_rdv", 32'(m_readdatavalid), 32'h0);
      end else begin
        check_eq("ct_rdv", 32'(m_readdatavalid), 32'(4'b0001 << ((c - 1) % 4)));
        check_eq("ct_data", m_readdata, 32'hC0DE0000 + 32'((c - 1) % 4));
      end
      for (int i = 0; i < N; i++) cnt[i] += int'(m_readdatavalid[i]);
      next_cycle();
      if (c == 7) m_read = 4'b0000;
    end
    for (int i = 0; i < N; i++) check_eq("ct_pulses", 32'(cnt[i]), 32'h2);

    // Byte write by master 1 then read by master 3
    set_master(1, 13'h1FFF, 4'b0011, 32'h11223344);
    m_write = 4'b0010;
    @(negedge clk);
    check_eq("bw_waitreq", 32'(m_waitrequest), 32'h0000000D);
    check_eq("bw_memwr", 32'(mem_write), 32'h1);
    check_eq("bw_be", 32'(mem_byteenable), 32'h00000003);
    check_eq("bw_wdata", mem_writedata, 32'h11223344);
    next_cycle();
    m_write = 4'b0000;
    set_master(3, 13'h1FFF, 4'b1111, 32'h0);
    m_read = 4'b1000;
    @(negedge clk);
    check_eq("bw_rd_waitreq", 32'(m_waitrequest), 32'h00000007);
    next_cycle();
    m_read = 4'b0000;
    @(negedge clk);
    check_eq("bw_rdv", 32'(m_readdatavalid), 32'h00000008);
    check_eq("bw_data", m_readdata, 32'hAAAA3344);

    // Read+write collision on master 0 (ptr is 0 here)
    next_cycle();
    set_master(0, 13'h0010, 4'b1111, 32'h12345678);
    m_read  = 4'b0001;
    m_write = 4'b0001;
    @(negedge clk);
    check_eq("col_waitreq", 32'(m_waitrequest), 32'h0000000E);
    check_eq("col_memwr", 32'(mem_write), 32'h1);
    check_eq("col_addr", 32'(mem_address), 32'h00000010);

    // Pointer skip: ptr = 1, only masters 0 and 3 request
    next_cycle();
    m_write = 4'b0000;
    m_read  = 4'b1001;
    @(negedge clk);
    check_eq("col_rdv", 32'(m_readdatavalid), 32'h0);
    check_eq("skip_first", 32'(m_waitrequest), 32'h00000007);
    next_cycle();
    m_read = 4'b0001;
    @(negedge clk);
    check_eq("skip_second", 32'(m_waitrequest), 32'h0000000E);
    check_eq("skip_rdv3", 32'(m_readdatavalid), 32'h00000008);
    check_eq("skip_data3", m_readdata, 32'hAAAA3344);
    next_cycle();
    m_read = 4'b0000;
    @(negedge clk);
    check_eq("skip_rdv0", 32'(m_readdatavalid), 32'h00000001);
    check_eq("col_memdata", m_readdata, 32'h12345678);

    // Reset while master 1's read is in flight (ptr is 1 here)
    next_cycle();
    set_master(1, 13'h0005, 4'b1111, 32'h0);
    set_master(2, 13'h0005, 4'b1111, 32'h0);
    m_read = 4'b0010;
    @(negedge clk);
    check_eq("rm_waitreq", 32'(m_waitrequest), 32'h0000000D);
    next_cycle();
    reset  = 1'b1;
    m_read = 4'b0101;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_eq("rm_rst_rdv", 32'(m_readdatavalid), 32'h0);
      check_eq("rm_rst_waitreq", 32'(m_waitrequest), 32'h0000000F);
      check_eq("rm_rst_cs", 32'(mem_chipselect), 32'h0);
      next_cycle();
    end
    reset = 1'b0;
    @(negedge clk);
    check_eq("rm_prio0", 32'(m_waitrequest), 32'h0000000E);
    check_eq("rm_rdv_after", 32'(m_readdatavalid), 32'h0);
    next_cycle();
    m_read = 4'b0100;
    @(negedge clk);
    check_eq("rm_next_waitreq", 32'(m_waitrequest), 32'h0000000B);
    check_eq("rm_rdv0", 32'(m_readdatavalid), 32'h00000001);
    check_eq("rm_data0", m_readdata, 32'h12345678);
    next_cycle();
    m_read = 4'b0000;
    @(negedge clk);
    check_eq("rm_rdv2", 32'(m_readdatavalid), 32'h00000004);
    check_eq("rm_data2", m_readdata, 32'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mpc_mem_arbiter.md
Name: mpc_mem_arbiter

Overview:
- Round-robin Avalon-MM arbiter: NUM_MASTERS core-side master ports share one single-port on-chip memory slave (13-bit word address, 32-bit data, byteenable, 1-cycle read latency).
- Sits directly upstream of the on-chip memory.
- Grants one transfer per cycle, returns read data with readdatavalid steered to the issuing master, and keeps the memory's clock enable asserted.

Parameters:
- NUM_MASTERS, 4: number of requesting master ports (2..8)
- ADDR_W, 13: word address width
- DATA_W, 32: data width
- BE_W, 4: byteenable width (DATA_W/8)
- READ_LATENCY, 1: memory read latency in cycles (1..3)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- m_address  in  NUM_MASTERS*ADDR_W  packed per-master addresses; master i at [i*ADDR_W +: ADDR_W]
- m_byteenable  in  NUM_MASTERS*BE_W  packed byteenables
- m_read  in  NUM_MASTERS  read requests
- m_write  in  NUM_MASTERS  write requests
- m_writedata  in  NUM_MASTERS*DATA_W  packed write data
- m_waitrequest  out  NUM_MASTERS  low = request accepted this cycle
- m_readdata  out  DATA_W  shared read data bus
- m_readdatavalid  out  NUM_MASTERS  one-hot read data valid
- mem_address  out  ADDR_W  to memory address
- mem_byteenable  out  BE_W  to memory byteenable
- mem_chipselect  out  1  to memory chipselect
- mem_write  out  1  to memory write
- mem_writedata  out  DATA_W  to memory writedata
- mem_clken  out  1  to memory clken
- mem_readdata  in  DATA_W  from memory readdata

Behaviour:
- Request: req[i] = m_read[i] | m_write[i]. Read and write both high = write; no readdatavalid is produced for it.
- Grant (combinational):
  - Pick the first requesting index at or after the priority pointer ptr, wrapping modulo NUM_MASTERS.
  - m_waitrequest[g] = 0 for the granted index g in the same cycle; all other bits = 1.
  - Every non-requesting master also sees waitrequest = 1.
- Pointer: on the clock edge after a grant, ptr <= (g+1) mod NUM_MASTERS. No grant means ptr holds. Consequence: a master requesting continuously against others gets at most 1 of every N_active transfers.
- Memory drive (combinational from the granted master):
  - mem_chipselect = grant valid.
  - mem_write = granted write.
  - mem_address, mem_byteenable, mem_writedata = granted master's fields.
  - No grant: chipselect = 0, write = 0, address/byteenable/writedata = 0.
- Read pipeline:
  - An accepted read pushes {valid=1, tag=g} into a READ_LATENCY-deep shift register.
  - A write or idle cycle pushes valid = 0.
  - At the output stage: m_readdatavalid[tag] = 1 and m_readdata = mem_readdata; otherwise m_readdatavalid = 0.
  - m_readdata is passed through unregistered at all times.
- Back-to-back reads from different masters every cycle are supported, with no bubbles.
- Read/write ordering:
  - A write granted in cycle t followed by a read to the same address in cycle t+1 must return the new data.
  - Arbitration order alone guarantees this; no extra hazard logic is required.
- mem_clken: 1 whenever reset = 0; 0 during reset.
- Reset (synchronous, active-high):
  - ptr <= 0 and all pipeline valid bits <= 0.
  - While reset = 1: m_waitrequest = all ones, mem_chipselect = 0, m_readdatavalid = 0.
  - Reads in flight when reset asserts are dropped; no readdatavalid follows them after reset deasserts.
- First cycle after reset: ptr = 0, so master 0 has top priority.
- Masters must hold address/data/command stable while waitrequest = 1 (Avalon rule). The arbiter does not latch requests.

Test Plan:
- Single read:
  - Stimulus: after reset, master 2 reads address 0x0005 (memory preloaded with 0xDEADBEEF).
  - Response: m_waitrequest[2] = 0 in the same cycle; one cycle later m_readdatavalid = 4'b0100 and m_readdata = 0xDEADBEEF.
- Contention fairness:
  - Stimulus: all 4 masters assert a read continuously for 8 cycles.
  - Response: grants occur in order 0,1,2,3,0,1,2,3; each readdatavalid bit pulses exactly twice, one cycle after its grant.
- Byte write then read:
  - Stimulus: master 1 writes 0x11223344 with BE = 4'b0011 to address 0x1FFF (previous contents 0xAAAAAAAA); next cycle master 3 reads 0x1FFF.
  - Response: master 3 receives 0xAAAA3344.
- Pointer skip:
  - Stimulus: ptr = 1; only masters 0 and 3 request.
  - Response: master 3 is granted first, ptr becomes 0, master 0 is granted next.
- Read+write collision:
  - Stimulus: master 0 asserts read and write together, writedata 0x12345678, address 0x0010.
  - Response: memory is written; no readdatavalid is produced.
- Reset mid-read:
  - Stimulus: master 1 read accepted, then reset asserted the next cycle for 2 cycles.
  - Response: m_readdatavalid stays 0 throughout; after release, master 0 has priority and waitrequest was all ones during reset.
